// File: rtl/mmio_periph_ctrl.sv
// Memory-mapped board-I/O peripheral: LEDs, debounced switches with
// sticky edge irq, square-wave tone generator and per-colour RGB PWM.
module mmio_periph_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LED_W     = 16,
  parameter int          N_SW      = 19,
  parameter int          N_RGB     = 2,
  parameter int          PWM_W     = 8,
  parameter int          DEB_CYC   = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          addr,
  input  logic                 wr_en,
  input  logic [31:0]          wr_data,
  input  logic                 rd_en,
  output logic [31:0]          rd_data,
  output logic                 rd_vld,
  input  logic [N_SW-1:0]      sw_in,
  output logic [LED_W-1:0]     leds,
  output logic [3*N_RGB-1:0]   rgb,
  output logic                 sound_l,
  output logic                 sound_r,
  output logic                 irq
);

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int CW = 3 * PWM_W;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYC - 1);

  // Bus decode
  logic       w_hit;
  logic [7:0] w_off;
  logic       w_wr;
  logic       w_rd;
  logic       w_sel_led;
  logic       w_sel_sw;
  logic       w_sel_edge;
  logic       w_sel_irqen;
  logic       w_sel_tone;
  logic [N_RGB-1:0] w_sel_rgb;
  logic [31:0] w_rdmux;
  logic       w_unused;

  // Registers
  logic [LED_W-1:0] r_led;
  logic [N_SW-1:0]  r_sw;
  logic [N_SW-1:0]  r_edge;
  logic [N_SW-1:0]  r_irq_en;
  logic [17:0]      r_tone;
  logic [N_RGB-1:0][CW-1:0] r_rgb_sh;
  logic [N_RGB-1:0][CW-1:0] r_act;
  logic [31:0]      r_rd_data;
  logic             r_rd_vld;
  logic             r_irq;

  // Switch path
  logic [N_SW-1:0]  r_sync1;
  logic [N_SW-1:0]  r_sync2;
  logic [N_SW-1:0]  r_samp;
  logic [DW-1:0]    r_deb_cnt;
  logic             w_tick;
  logic [N_SW-1:0]  w_agree;
  logic [N_SW-1:0]  w_sw_nxt;
  logic [N_SW-1:0]  w_rise;
  logic [N_SW-1:0]  w_w1c;

  // Tone / PWM
  logic [15:0]      r_hc;
  logic             r_phase;
  logic [15:0]      w_half;
  logic             w_tone_idle;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic             w_wrap;
  logic [3*N_RGB-1:0] w_rgb;

  assign w_hit       = (addr[31:8] == BASE_ADDR[31:8]);
  assign w_off       = addr[7:0];
  assign w_wr        = wr_en & w_hit;
  assign w_rd        = rd_en & w_hit;
  assign w_sel_led   = (w_off == 8'h00);
  assign w_sel_sw    = (w_off == 8'h04);
  assign w_sel_edge  = (w_off == 8'h08);
  assign w_sel_irqen = (w_off == 8'h0C);
  assign w_sel_tone  = (w_off == 8'h10);
  assign w_unused    = ^{wr_data, w_sel_sw};

  // RGB register selects, one word per LED from 0x20
  always_comb begin
    w_sel_rgb = '0;
    for (int i = 0; i < N_RGB; i++) begin
      w_sel_rgb[i] = (w_off == 8'(32 + 4 * i));
    end
  end

  // Read-back multiplexer; unimplemented bits stay 0
  always_comb begin
    w_rdmux = '0;
    unique case (1'b1)
      w_sel_led:   w_rdmux[LED_W-1:0] = r_led;
      w_sel_sw:    w_rdmux[N_SW-1:0]  = r_sw;
      w_sel_edge:  w_rdmux[N_SW-1:0]  = r_edge;
      w_sel_irqen: w_rdmux[N_SW-1:0]  = r_irq_en;
      w_sel_tone:  w_rdmux[17:0]      = r_tone;
      default: ;
    endcase
    for (int i = 0; i < N_RGB; i++) begin
      if (w_sel_rgb[i]) w_rdmux[CW-1:0] = r_rgb_sh[i];
    end
  end

  // Read response, one cycle after the strobe, zero when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_vld  <= w_rd;
      r_rd_data <= w_rd ? w_rdmux : '0;
    end
  end

  // Plain RW registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led    <= '0;
      r_irq_en <= '0;
      r_tone   <= '0;
      r_rgb_sh <= '0;
    end else if (w_wr) begin
      if (w_sel_led)   r_led    <= wr_data[LED_W-1:0];
      if (w_sel_irqen) r_irq_en <= wr_data[N_SW-1:0];
      if (w_sel_tone)  r_tone   <= wr_data[17:0];
      for (int i = 0; i < N_RGB; i++) begin
        if (w_sel_rgb[i]) r_rgb_sh[i] <= wr_data[CW-1:0];
      end
    end
  end

  assign w_tick   = (r_deb_cnt == DEB_MAX);
  assign w_agree  = ~(r_samp ^ r_sync2);
  assign w_sw_nxt = w_tick ? ((r_sw & ~w_agree) | (r_sync2 & w_agree))
                           : r_sw;
  assign w_rise   = w_sw_nxt & ~r_sw;
  assign w_w1c    = (w_wr && w_sel_edge) ? wr_data[N_SW-1:0] : '0;

  // Synchronise, then accept a bit when two tick samples agree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_samp    <= '0;
      r_deb_cnt <= '0;
      r_sw      <= '0;
    end else begin
      r_sync1 <= sw_in;
      r_sync2 <= r_sync1;
      r_sw    <= w_sw_nxt;
      if (w_tick) begin
        r_deb_cnt <= '0;
        r_samp    <= r_sync2;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  // Sticky rising-edge flags; a new edge wins over a W1C clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_edge <= (r_edge & ~w_w1c) | w_rise;
      r_irq  <= |(r_edge & r_irq_en);
    end
  end

  assign w_half      = r_tone[15:0];
  assign w_tone_idle = (w_half == 16'd0) || !(r_tone[16] || r_tone[17]);

  // Half-period counter toggles the tone phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hc    <= '0;
      r_phase <= 1'b0;
    end else if ((w_wr && w_sel_tone) || w_tone_idle) begin
      r_hc    <= '0;
      r_phase <= 1'b0;
    end else if (r_hc == w_half - 16'd1) begin
      r_hc    <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_hc <= r_hc + 16'd1;
    end
  end

  assign w_wrap = &r_pwm_cnt;

  // Free-running PWM counter; duties latch only at the wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
      r_act     <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (w_wrap) r_act <= r_rgb_sh;
    end
  end

  // Per-colour compare against the active duty
  always_comb begin
    w_rgb = '0;
    for (int i = 0; i < N_RGB; i++) begin
      for (int c = 0; c < 3; c++) begin
        w_rgb[3*i+c] = (r_pwm_cnt < r_act[i][c*PWM_W +: PWM_W]);
      end
    end
  end

  assign rgb     = w_rgb;
  assign leds    = r_led;
  assign sound_l = r_phase & r_tone[16];
  assign sound_r = r_phase & r_tone[17];
  assign irq     = r_irq;
  assign rd_data = r_rd_data;
  assign rd_vld  = r_rd_vld;

endmodule

// File: tb/tb_mmio_periph_ctrl.sv
// Directed bench for mmio_periph_ctrl with small PWM and debounce
// parameters so every feature is exercised in a few hundred cycles.
module tb_mmio_periph_ctrl;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int LED_W = 16;
  localparam int N_SW  = 8;
  localparam int N_RGB = 2;

  logic              clk;
  logic              rst_n;
  logic [31:0]       addr;
  logic              wr_en;
  logic [31:0]       wr_data;
  logic              rd_en;
  logic [31:0]       rd_data;
  logic              rd_vld;
  logic [N_SW-1:0]   sw_in;
  logic [LED_W-1:0]  leds;
  logic [3*N_RGB-1:0] rgb;
  logic              sound_l;
  logic              sound_r;
  logic              irq;

  int n_chk;
  int n_err;
  logic [31:0] rd;
  logic        rv;

  mmio_periph_ctrl #(
    .BASE_ADDR (BASE),
    .LED_W     (LED_W),
    .N_SW      (N_SW),
    .N_RGB     (N_RGB),
    .PWM_W     (4),
    .DEB_CYC   (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .rd_vld  (rd_vld),
    .sw_in   (sw_in),
    .leds    (leds),
    .rgb     (rgb),
    .sound_l (sound_l),
    .sound_r (sound_r),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d,
                        output logic v);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d = rd_data;
    v = rd_vld;
  endtask

  initial begin
    int hi;
    int found;
    logic prev;
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; addr = '0; wr_en = 1'b0; wr_data = '0;
    rd_en = 1'b0; sw_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_leds", leds, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_snd", {sound_l, sound_r}, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rdvld", rd_vld, 0);
    chk("rst_rddata", rd_data, 0);
    rst_n = 1'b1;

    // LED write / read-back
    bus_wr(BASE + 32'h00, 32'h0000_A5A5);
    chk("led_out", leds, 32'hA5A5);
    bus_rd(BASE + 32'h00, rd, rv);
    chk("led_rdvld", rv, 1);
    chk("led_rd", rd, 32'hA5A5);
    @(negedge clk);
    chk("rdvld_drop", rd_vld, 0);
    chk("rddata_idle", rd_data, 0);
    bus_rd(BASE + 32'h14, rd, rv);
    chk("unmap_vld", rv, 1);
    chk("unmap_rd", rd, 0);
    @(negedge clk);
    addr = BASE; wr_data = 32'h5A5A; wr_en = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rw_same_old", rd_data, 32'hA5A5);
    chk("rw_same_new", leds, 32'h5A5A);
    bus_wr(BASE + 32'h04, 32'hFF);
    bus_rd(BASE + 32'h04, rd, rv);
    chk("sw_ro", rd, 0);

    // Debounce with a one-tick bounce on switch 3
    @(negedge clk);
    sw_in[3] = 1'b1;
    repeat (4) @(negedge clk);
    sw_in[3] = 1'b0;
    repeat (4) @(negedge clk);
    sw_in[3] = 1'b1;
    bus_rd(BASE + 32'h04, rd, rv);
    chk("sw_bounce", rd, 0);
    repeat (20) @(negedge clk);
    bus_rd(BASE + 32'h04, rd, rv);
    chk("sw_stable", rd, 32'h8);
    bus_rd(BASE + 32'h08, rd, rv);
    chk("edge_flag", rd, 32'h8);
    chk("irq_masked", irq, 0);
    bus_wr(BASE + 32'h0C, 32'h8);
    repeat (2) @(negedge clk);
    chk("irq_on", irq, 1);
    bus_wr(BASE + 32'h08, 32'h8);
    @(negedge clk);
    chk("irq_w1c", irq, 0);
    bus_rd(BASE + 32'h08, rd, rv);
    chk("edge_cleared", rd, 0);

    // Continuous W1C while switch 5 rises: set must win once
    bus_wr(BASE + 32'h0C, 32'h28);
    @(negedge clk);
    addr = BASE + 32'h08; wr_data = 32'h20; wr_en = 1'b1;
    sw_in[5] = 1'b1;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      hi += int'(irq);
    end
    wr_en = 1'b0;
    chk("set_beats_clr", hi, 1);
    bus_rd(BASE + 32'h04, rd, rv);
    chk("sw_two", rd, 32'h28);

    // Tone generator, half period 3, both channels
    bus_wr(BASE + 32'h10, 32'h0003_0003);
    for (int k = 0; k < 12; k++) begin
      chk("tone_l", sound_l, (k / 3) % 2);
      chk("tone_r", sound_r, (k / 3) % 2);
      @(negedge clk);
    end
    bus_wr(BASE + 32'h10, 32'h0001_0000);
    for (int k = 0; k < 4; k++) begin
      chk("tone_off", {sound_l, sound_r}, 0);
      @(negedge clk);
    end
    bus_rd(BASE + 32'h10, rd, rv);
    chk("tone_rd", rd, 32'h0001_0000);

    // PWM, 4-bit counter
    bus_wr(BASE + 32'h20, 32'h4);
    repeat (20) @(negedge clk);
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      hi += int'(rgb[0]);
      chk("pwm_gb_off", {26'd0, rgb[5:1]}, 0);
      @(negedge clk);
    end
    chk("pwm_duty4", hi, 4);
    found = 0;
    prev = rgb[0];
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (rgb[0] && !prev) found = 1;
      else prev = rgb[0];
    end
    chk("pwm_sync", found, 1);
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      hi += int'(rgb[0]);
      if (k == 5) begin
        addr = BASE + 32'h20; wr_data = 32'hC; wr_en = 1'b1;
      end
      if (k == 6) wr_en = 1'b0;
      @(negedge clk);
    end
    chk("pwm_old_period", hi, 4);
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      hi += int'(rgb[0]);
      @(negedge clk);
    end
    chk("pwm_new_period", hi, 12);
    bus_rd(BASE + 32'h20, rd, rv);
    chk("rgb_shadow_rd", rd, 32'hC);
    bus_wr(BASE + 32'h20, 32'h0);
    repeat (20) @(negedge clk);
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      hi += int'(rgb[0]);
      @(negedge clk);
    end
    chk("pwm_zero", hi, 0);

    // Reset in the middle of a read
    bus_wr(BASE + 32'h00, 32'h00FF);
    bus_wr(BASE + 32'h10, 32'h0003_0002);
    bus_wr(BASE + 32'h24, 32'hF);
    repeat (20) @(negedge clk);
    chk("pre_rst_leds", leds, 32'hFF);
    addr = BASE; rd_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_leds", leds, 0);
    chk("arst_rgb", rgb, 0);
    chk("arst_snd", {sound_l, sound_r}, 0);
    chk("arst_irq", irq, 0);
    chk("arst_rdvld", rd_vld, 0);
    @(negedge clk);
    chk("arst_no_resp", rd_vld, 0);
    rd_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_vld", rd_vld, 0);
    repeat (20) @(negedge clk);
    bus_rd(BASE + 32'h08, rd, rv);
    chk("held_high_edge", rd, 32'h28);
    bus_rd(BASE + 32'h10, rd, rv);
    chk("tone_reset", rd, 0);

    // Accesses outside the window
    bus_wr(BASE + 32'h00, 32'h1234);
    bus_wr(32'h4000_0100, 32'hFFFF);
    chk("miss_wr_led", leds, 32'h1234);
    bus_rd(32'h4000_0100, rd, rv);
    chk("miss_rdvld", rv, 0);
    chk("miss_rddata", rd, 0);
    bus_rd(BASE + 32'h00, rd, rv);
    chk("miss_led_rd", rd, 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
